// File: rtl/rib_arbiter.sv
// rib_arbiter: three-master, one-slave arbiter/sequencer for the RIB bus.
//   m0 = debug master, m1 = core data port, m2 = core instruction port.
//   Fixed priority m0 > m1 > m2, with m2 promoted after STARVE_LIMIT lost
//   arbitrations. A watchdog force-completes a transfer with err_o if the
//   slave does not ack within TIMEOUT+1 ACCESS cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mX_req_i/we/size/addr/wdata   master request and fields, held until ack
//   mX_rdata_o, mX_ack_o     read data and one-cycle completion pulse
//   s_req_o/we/size/addr/wdata    slave request (fields registered at grant)
//   s_rdata_i, s_ack_i       slave read data and completion
//   hold_flag_o              core stall request (combinational)
//   err_o                    timeout pulse, coincident with the forced ack
//
// state  | meaning
// IDLE   | no transfer; arbitrate among pending requests
// ACCESS | s_req_o asserted, waiting for s_ack_i or watchdog expiry
// RESP   | one-cycle ack to the granted master
module rib_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [2:0]  m0_size_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic [31:0] m0_rdata_o,
   output logic        m0_ack_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [2:0]  m1_size_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic [31:0] m1_rdata_o,
   output logic        m1_ack_o,
   input  logic        m2_req_i,
   input  logic        m2_we_i,
   input  logic [2:0]  m2_size_i,
   input  logic [31:0] m2_addr_i,
   input  logic [31:0] m2_wdata_i,
   output logic [31:0] m2_rdata_o,
   output logic        m2_ack_o,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [2:0]  s_size_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   input  logic [31:0] s_rdata_i,
   input  logic        s_ack_i,
   output logic        hold_flag_o,
   output logic        err_o
);

   localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
   localparam logic [7:0] WAIT_MAX   = 8'(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t      state, state_nxt;
   logic [1:0]  gnt;
   logic [7:0]  wait_cnt;
   logic [2:0]  starve_cnt;
   logic        err_q;
   logic        any_req;
   logic        timeout;
   logic [1:0]  win;
   logic        win_we;
   logic [2:0]  win_size;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // next-state and winner selection
   always_comb begin
      any_req   = m0_req_i | m1_req_i | m2_req_i;
      timeout   = (wait_cnt == WAIT_MAX);
      state_nxt = state;
      if (starve_cnt == STARVE_MAX && m2_req_i) win = 2'd2;
      else if (m0_req_i)                        win = 2'd0;
      else if (m1_req_i)                        win = 2'd1;
      else                                      win = 2'd2;
      case (win)
         2'd0: begin
            win_we = m0_we_i; win_size = m0_size_i;
            win_addr = m0_addr_i; win_wdata = m0_wdata_i;
         end
         2'd1: begin
            win_we = m1_we_i; win_size = m1_size_i;
            win_addr = m1_addr_i; win_wdata = m1_wdata_i;
         end
         default: begin
            win_we = m2_we_i; win_size = m2_size_i;
            win_addr = m2_addr_i; win_wdata = m2_wdata_i;
         end
      endcase
      case (state)
         ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
         ST_ACCESS: if (s_ack_i || timeout) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // datapath: grant latch, slave fields, counters, read data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt        <= 2'd0;
         wait_cnt   <= 8'd0;
         starve_cnt <= 3'd0;
         err_q      <= 1'b0;
         s_we_o     <= 1'b0;
         s_size_o   <= 3'd0;
         s_addr_o   <= 32'd0;
         s_wdata_o  <= 32'd0;
         m0_rdata_o <= 32'd0;
         m1_rdata_o <= 32'd0;
         m2_rdata_o <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  gnt       <= win;
                  wait_cnt  <= 8'd0;
                  s_we_o    <= win_we;
                  s_size_o  <= win_size;
                  s_addr_o  <= win_addr;
                  s_wdata_o <= win_wdata;
                  if (win == 2'd2)
                     starve_cnt <= 3'd0;
                  else if (m2_req_i && starve_cnt != STARVE_MAX)
                     starve_cnt <= starve_cnt + 3'd1;
               end
            end
            ST_ACCESS: begin
               if (s_ack_i || timeout) begin
                  // a timed-out transfer returns zero read data
                  err_q <= ~s_ack_i;
                  case (gnt)
                     2'd0:    m0_rdata_o <= s_ack_i ? s_rdata_i : 32'd0;
                     2'd1:    m1_rdata_o <= s_ack_i ? s_rdata_i : 32'd0;
                     default: m2_rdata_o <= s_ack_i ? s_rdata_i : 32'd0;
                  endcase
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // outputs
   always_comb begin
      s_req_o  = (state == ST_ACCESS);
      m0_ack_o = (state == ST_RESP) && (gnt == 2'd0);
      m1_ack_o = (state == ST_RESP) && (gnt == 2'd1);
      m2_ack_o = (state == ST_RESP) && (gnt == 2'd2);
      err_o    = (state == ST_RESP) && err_q;
   end

   assign hold_flag_o = (m1_req_i & ~m1_ack_o) | (m2_req_i & ~m2_ack_o);

endmodule
